// File: rtl/cnna_acc_pkg.sv
// Shared definitions for the accumulate-and-requantize block: FSM state encoding
// and default datapath widths.
package cnna_acc_pkg;

  localparam int DEF_DIN_WIDTH  = 32;
  localparam int DEF_ACC_WIDTH  = 44;
  localparam int DEF_DOUT_WIDTH = 16;
  localparam int DEF_LEN_WIDTH  = 12;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RND,
    OUT
  } state_t;

endpackage

// File: rtl/cnna_acc_reqnt_32s_16_if.sv
// Configuration, product-stream and result-stream signals of the accumulator.
// The master drives products and config; the slave (the accumulator) returns results.
interface cnna_acc_reqnt_32s_16_if
  import cnna_acc_pkg::*;
#(
  parameter int DIN_WIDTH  = DEF_DIN_WIDTH,
  parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);

  logic [LEN_WIDTH-1:0]         cfg_len;
  logic [4:0]                   cfg_shift;
  logic                         cfg_relu;
  logic signed [DIN_WIDTH-1:0]  din;
  logic                         din_valid;
  logic                         din_ready;
  logic signed [DOUT_WIDTH-1:0] dout;
  logic                         dout_valid;
  logic                         dout_ready;
  logic                         busy;

  modport master (
    output cfg_len, cfg_shift, cfg_relu, din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, busy
  );

  modport slave (
    input  cfg_len, cfg_shift, cfg_relu, din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, busy
  );

endinterface

// File: rtl/cnna_acc_requant.sv
// Combinational requantizer: round-half-up, arithmetic shift, optional ReLU,
// then saturation of the wide accumulator into the signed output range.
module cnna_acc_requant
  import cnna_acc_pkg::*;
#(
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int DOUT_WIDTH = DEF_DOUT_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  logic        [4:0]            shift,
  input  logic                         relu,
  output logic signed [DOUT_WIDTH-1:0] result
);

  // One guard bit so adding the rounding bias can never wrap.
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH-DOUT_WIDTH+2){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_WIDTH:0] bias;
  logic signed [ACC_WIDTH:0] wide;
  logic signed [ACC_WIDTH:0] shifted;

  always_comb begin
    // NOTE: every variable written here gets a value on every path, starting
    // with a default, so no latch can be inferred.
    result  = '0;
    bias    = ((ACC_WIDTH+1)'(1) << shift) >> 1;
    wide    = (ACC_WIDTH+1)'(acc) + bias;
    shifted = wide >>> shift;
    if (relu && shifted[ACC_WIDTH]) shifted = '0;
    if (shifted > SAT_MAX)      result = SAT_MAX[DOUT_WIDTH-1:0];
    else if (shifted < SAT_MIN) result = SAT_MIN[DOUT_WIDTH-1:0];
    else                        result = shifted[DOUT_WIDTH-1:0];
  end

endmodule

// File: rtl/cnna_acc_reqnt_32s_16.sv
// Windowed accumulator: sums cfg_len signed products, requantizes the sum once
// per window and holds the result until the consumer takes it.
module cnna_acc_reqnt_32s_16
  import cnna_acc_pkg::*;
#(
  parameter int DIN_WIDTH  = DEF_DIN_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  cnna_acc_reqnt_32s_16_if.slave bus
);

  state_t                       state, state_nxt;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic        [LEN_WIDTH-1:0]  cnt;
  logic        [LEN_WIDTH-1:0]  len_q;
  logic        [LEN_WIDTH-1:0]  len_eff;
  logic        [4:0]            shift_q;
  logic                         relu_q;
  logic signed [DOUT_WIDTH-1:0] dout_q;
  logic signed [DOUT_WIDTH-1:0] requant_out;
  logic signed [DIN_WIDTH-1:0]  din_s;
  logic                         beat;

  assign din_s   = bus.din;
  assign len_eff = (bus.cfg_len == '0) ? LEN_WIDTH'(1) : bus.cfg_len;

  // Handshake outputs decode the state only, never the opposite handshake.
  assign bus.din_ready  = (state == IDLE) || (state == ACC);
  assign bus.dout_valid = (state == OUT);
  assign bus.busy       = (state != IDLE);
  assign bus.dout       = dout_q;
  assign beat           = bus.din_valid && bus.din_ready;

  always_ff @(posedge ap_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (beat) state_nxt = (len_eff == LEN_WIDTH'(1)) ? RND : ACC;
      ACC:     if (beat && ((cnt + LEN_WIDTH'(1)) == len_q)) state_nxt = RND;
      RND:     state_nxt = OUT;
      OUT:     if (bus.dout_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Config is captured on the first beat only so mid-window changes are ignored.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc     <= '0;
      cnt     <= '0;
      len_q   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      unique case (state)
        IDLE: if (beat) begin
          len_q   <= len_eff;
          shift_q <= bus.cfg_shift;
          relu_q  <= bus.cfg_relu;
          acc     <= ACC_WIDTH'(din_s);
          cnt     <= LEN_WIDTH'(1);
        end
        ACC: if (beat) begin
          acc <= acc + ACC_WIDTH'(din_s);
          cnt <= cnt + LEN_WIDTH'(1);
        end
        RND:     dout_q <= requant_out;
        default: ;
      endcase
    end
  end

  cnna_acc_requant #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DOUT_WIDTH (DOUT_WIDTH)
  ) u_requant (
    .acc    (acc),
    .shift  (shift_q),
    .relu   (relu_q),
    .result (requant_out)
  );

endmodule
